hamming74_dec: RTL and testbench

- Pipelined Hamming(7,4) SECDED decoder. It is the receive-side partner of the team's hamming_c encoder.
- Accepts one 7-bit codeword plus its overall parity bit per valid/ready handshake. Corrects any single-bit error, detects double-bit errors, and returns the 4-bit data word with error flags.
- Keeps saturating error counters for link-health monitoring.
- Sits between the channel/receive buffer and the consumer of recovered nibbles.

---
 rtl/hamming74_dec.sv | 145 ++++++++++++++
 tb/tb_hamming74_dec.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming74_dec.sv
// Two-stage Hamming(7,4) SECDED decoder with valid/ready flow control.
// Also keeps saturating corrected/uncorrected error counters for link health.
module hamming74_dec #(
  parameter int CNT_W = 8
) (
  input  logic             ip_clk,
  input  logic             ip_rst_n,
  input  logic             ip_valid,
  output logic             op_ready,
  input  logic [6:0]       ip_hamm_code,
  input  logic             ip_parity,
  output logic             op_valid,
  input  logic             ip_ready,
  output logic [3:0]       op_data,
  output logic             op_single_err,
  output logic             op_double_err,
  output logic             op_parity_err,
  output logic [2:0]       op_err_pos,
  input  logic             ip_cnt_clr,
  output logic [CNT_W-1:0] op_corr_cnt,
  output logic [CNT_W-1:0] op_uncorr_cnt
);

  typedef struct packed {
    logic [6:0] code;
    logic [2:0] syn;
    logic       pchk;
  } s1_t;

  typedef struct packed {
    logic [3:0] data;
    logic       single_err;
    logic       double_err;
    logic       parity_err;
    logic [2:0] err_pos;
  } s2_t;

  logic s1_valid;
  logic s2_valid;
  logic s1_en;
  logic s2_en;
  logic dlv;

  s1_t s1_q;
  s1_t s1_d;
  s2_t s2_q;
  s2_t s2_d;

  logic [6:0] flip;
  logic [6:0] fixed;
  logic       syn_nz;

  assign s2_en    = !s2_valid || ip_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign op_ready = s1_en;
  assign op_valid = s2_valid;
  assign dlv      = s2_valid && ip_ready;

  // Syndrome and overall parity check on the incoming word
  always_comb begin
    s1_d        = '0;
    s1_d.code   = ip_hamm_code;
    s1_d.syn[0] = ip_hamm_code[0] ^ ip_hamm_code[2]
                ^ ip_hamm_code[4] ^ ip_hamm_code[6];
    s1_d.syn[1] = ip_hamm_code[1] ^ ip_hamm_code[2]
                ^ ip_hamm_code[5] ^ ip_hamm_code[6];
    s1_d.syn[2] = ip_hamm_code[3] ^ ip_hamm_code[4]
                ^ ip_hamm_code[5] ^ ip_hamm_code[6];
    s1_d.pchk   = (^ip_hamm_code) ^ ip_parity;
  end

  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_en) begin
      s1_valid <= ip_valid;
      if (ip_valid) s1_q <= s1_d;
    end
  end

  assign syn_nz = |s1_q.syn;

  always_comb begin
    flip = '0;
    if (syn_nz) flip = 7'd1 << (s1_q.syn - 3'd1);
  end

  always_comb begin
    s2_d  = '0;
    fixed = s1_q.code;
    unique case (1'b1)
      (!syn_nz && !s1_q.pchk): begin
      end
      (syn_nz && s1_q.pchk): begin
        fixed           = s1_q.code ^ flip;
        s2_d.single_err = 1'b1;
        s2_d.err_pos    = s1_q.syn;
      end
      (!syn_nz && s1_q.pchk): begin
        s2_d.single_err = 1'b1;
        s2_d.parity_err = 1'b1;
      end
      (syn_nz && !s1_q.pchk): begin
        s2_d.double_err = 1'b1;
      end
      default: begin
      end
    endcase
    s2_d.data = {fixed[6], fixed[5], fixed[4], fixed[2]};
  end

  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_q <= s2_d;
    end
  end

  assign op_data       = s2_q.data;
  assign op_single_err = s2_q.single_err;
  assign op_double_err = s2_q.double_err;
  assign op_parity_err = s2_q.parity_err;
  assign op_err_pos    = s2_q.err_pos;

  // Counters only see delivered words; clear wins over increment
  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      op_corr_cnt   <= '0;
      op_uncorr_cnt <= '0;
    end else if (ip_cnt_clr) begin
      op_corr_cnt   <= '0;
      op_uncorr_cnt <= '0;
    end else if (dlv) begin
      if (s2_q.single_err && (op_corr_cnt != '1))
        op_corr_cnt <= op_corr_cnt + 1'b1;
      if (s2_q.double_err && (op_uncorr_cnt != '1))
        op_uncorr_cnt <= op_uncorr_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming74_dec.sv
// Directed bench for hamming74_dec: decode classes, backpressure,
// counter saturation/clear and asynchronous reset.
module tb_hamming74_dec;

  logic       ip_clk;
  logic       ip_rst_n;
  logic       ip_valid;
  logic       op_ready;
  logic [6:0] ip_hamm_code;
  logic       ip_parity;
  logic       op_valid;
  logic       ip_ready;
  logic [3:0] op_data;
  logic       op_single_err;
  logic       op_double_err;
  logic       op_parity_err;
  logic [2:0] op_err_pos;
  logic       ip_cnt_clr;
  logic [7:0] op_corr_cnt;
  logic [7:0] op_uncorr_cnt;

  int checks;
  int errors;
  int exp_corr;

  hamming74_dec #(.CNT_W(8)) dut (
    .ip_clk        (ip_clk),
    .ip_rst_n      (ip_rst_n),
    .ip_valid      (ip_valid),
    .op_ready      (op_ready),
    .ip_hamm_code  (ip_hamm_code),
    .ip_parity     (ip_parity),
    .op_valid      (op_valid),
    .ip_ready      (ip_ready),
    .op_data       (op_data),
    .op_single_err (op_single_err),
    .op_double_err (op_double_err),
    .op_parity_err (op_parity_err),
    .op_err_pos    (op_err_pos),
    .ip_cnt_clr    (ip_cnt_clr),
    .op_corr_cnt   (op_corr_cnt),
    .op_uncorr_cnt (op_uncorr_cnt)
  );

  initial ip_clk = 1'b0;
  always #5 ip_clk = ~ip_clk;

  task automatic step();
    @(posedge ip_clk);
    #1;
  endtask

  // Offer one word on an empty pipe and wait the two-cycle latency
  task automatic xfer(input logic [6:0] code, input logic par);
    ip_hamm_code = code;
    ip_parity    = par;
    ip_valid     = 1'b1;
    step();
    ip_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    ip_rst_n     = 1'b0;
    ip_valid     = 1'b0;
    ip_ready     = 1'b1;
    ip_cnt_clr   = 1'b0;
    ip_hamm_code = '0;
    ip_parity    = 1'b0;
    repeat (3) step();
    checks++;
    if (op_valid !== 1'b0 || op_data !== 4'h0 || op_err_pos !== 3'd0) begin
      errors++;
      $display("FAIL reset_out got v=%b d=%h p=%0d want 0 0 0",
               op_valid, op_data, op_err_pos);
    end
    checks++;
    if (op_corr_cnt !== 8'd0 || op_uncorr_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d %0d want 0 0",
               op_corr_cnt, op_uncorr_cnt);
    end
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", op_ready);
    end
    ip_rst_n = 1'b1;
    step();
  endtask

  task automatic test_clean();
    ip_hamm_code = 7'b0101101;
    ip_parity    = 1'b0;
    ip_valid     = 1'b1;
    step();
    ip_valid = 1'b0;
    checks++;
    if (op_valid !== 1'b0) begin
      errors++;
      $display("FAIL clean_lat1 op_valid got %b want 0", op_valid);
    end
    step();
    checks++;
    if (op_valid !== 1'b1 || op_data !== 4'h5) begin
      errors++;
      $display("FAIL clean_out got v=%b d=%h want 1 5", op_valid, op_data);
    end
    checks++;
    if ({op_single_err, op_double_err, op_parity_err} !== 3'b000 ||
        op_err_pos !== 3'd0) begin
      errors++;
      $display("FAIL clean_flags got %b%b%b pos=%0d want 000 0",
               op_single_err, op_double_err, op_parity_err, op_err_pos);
    end
    step();
    checks++;
    if (op_valid !== 1'b0) begin
      errors++;
      $display("FAIL clean_drain op_valid got %b want 0", op_valid);
    end
  endtask

  task automatic test_single();
    xfer(7'b0101001, 1'b0);
    checks++;
    if (op_valid !== 1'b1 || op_data !== 4'h5 || op_single_err !== 1'b1 ||
        op_err_pos !== 3'd3 || op_double_err !== 1'b0) begin
      errors++;
      $display("FAIL single got v=%b d=%h s=%b dbl=%b pos=%0d want 1 5 1 0 3",
               op_valid, op_data, op_single_err, op_double_err, op_err_pos);
    end
    step();
    exp_corr++;
    checks++;
    if (op_corr_cnt !== 8'(exp_corr)) begin
      errors++;
      $display("FAIL single_cnt got %0d want %0d", op_corr_cnt, exp_corr);
    end
  endtask

  task automatic test_double();
    xfer(7'b0101110, 1'b0);
    checks++;
    if (op_double_err !== 1'b1 || op_single_err !== 1'b0 ||
        op_err_pos !== 3'd0 || op_data !== 4'h5) begin
      errors++;
      $display("FAIL double got dbl=%b s=%b pos=%0d d=%h want 1 0 0 5",
               op_double_err, op_single_err, op_err_pos, op_data);
    end
    step();
    checks++;
    if (op_uncorr_cnt !== 8'd1 || op_corr_cnt !== 8'(exp_corr)) begin
      errors++;
      $display("FAIL double_cnt got %0d %0d want 1 %0d",
               op_uncorr_cnt, op_corr_cnt, exp_corr);
    end
  endtask

  task automatic test_parity();
    xfer(7'b0101101, 1'b1);
    checks++;
    if (op_parity_err !== 1'b1 || op_single_err !== 1'b1 ||
        op_double_err !== 1'b0 || op_err_pos !== 3'd0 ||
        op_data !== 4'h5) begin
      errors++;
      $display("FAIL parity got p=%b s=%b dbl=%b pos=%0d d=%h want 1 1 0 0 5",
               op_parity_err, op_single_err, op_double_err,
               op_err_pos, op_data);
    end
    step();
    exp_corr++;
  endtask

  task automatic test_positions();
    logic [6:0] good;
    good = 7'b0101101;
    for (int i = 0; i < 7; i++) begin
      xfer(good ^ (7'd1 << i), 1'b0);
      checks++;
      if (op_single_err !== 1'b1 || op_err_pos !== 3'(i + 1) ||
          op_data !== 4'h5 || op_parity_err !== 1'b0) begin
        errors++;
        $display("FAIL pos_bit%0d got s=%b pos=%0d d=%h want 1 %0d 5",
                 i, op_single_err, op_err_pos, op_data, i + 1);
      end
      step();
      exp_corr++;
    end
    checks++;
    if (op_corr_cnt !== 8'(exp_corr)) begin
      errors++;
      $display("FAIL pos_cnt got %0d want %0d", op_corr_cnt, exp_corr);
    end
  endtask

  task automatic test_backpressure();
    ip_ready     = 1'b0;
    ip_valid     = 1'b1;
    ip_hamm_code = 7'b0101101;
    ip_parity    = 1'b0;
    step();
    ip_hamm_code = 7'b1010010;
    ip_parity    = 1'b1;
    step();
    ip_hamm_code = 7'b0011110;
    ip_parity    = 1'b0;
    checks++;
    if (op_ready !== 1'b0 || op_valid !== 1'b1 || op_data !== 4'h5) begin
      errors++;
      $display("FAIL bp_full got rdy=%b v=%b d=%h want 0 1 5",
               op_ready, op_valid, op_data);
    end
    repeat (2) step();
    checks++;
    if (op_ready !== 1'b0 || op_valid !== 1'b1 || op_data !== 4'h5 ||
        op_single_err !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold got rdy=%b v=%b d=%h s=%b want 0 1 5 0",
               op_ready, op_valid, op_data, op_single_err);
    end
    ip_ready = 1'b1;
    #1;
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release op_ready got %b want 1", op_ready);
    end
    step();
    ip_valid = 1'b0;
    checks++;
    if (op_valid !== 1'b1 || op_data !== 4'hA) begin
      errors++;
      $display("FAIL bp_word1 got v=%b d=%h want 1 a", op_valid, op_data);
    end
    step();
    checks++;
    if (op_valid !== 1'b1 || op_data !== 4'h3) begin
      errors++;
      $display("FAIL bp_word2 got v=%b d=%h want 1 3", op_valid, op_data);
    end
    step();
    checks++;
    if (op_valid !== 1'b0 || op_corr_cnt !== 8'(exp_corr)) begin
      errors++;
      $display("FAIL bp_drain got v=%b cnt=%0d want 0 %0d",
               op_valid, op_corr_cnt, exp_corr);
    end
  endtask

  task automatic test_back_to_back();
    ip_ready     = 1'b1;
    ip_hamm_code = 7'b0101001;
    ip_parity    = 1'b0;
    ip_valid     = 1'b1;
    for (int i = 0; i < 300; i++) begin
      checks++;
      if (op_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready word %0d got %b want 1", i, op_ready);
      end
      step();
    end
    ip_valid = 1'b0;
    repeat (3) step();
    checks++;
    if (op_corr_cnt !== 8'd255 || op_uncorr_cnt !== 8'd1) begin
      errors++;
      $display("FAIL sat_cnt got %0d %0d want 255 1",
               op_corr_cnt, op_uncorr_cnt);
    end
    xfer(7'b0101001, 1'b0);
    ip_cnt_clr = 1'b1;
    step();
    ip_cnt_clr = 1'b0;
    checks++;
    if (op_corr_cnt !== 8'd0 || op_uncorr_cnt !== 8'd0) begin
      errors++;
      $display("FAIL clr_cnt got %0d %0d want 0 0",
               op_corr_cnt, op_uncorr_cnt);
    end
  endtask

  task automatic test_async_reset();
    xfer(7'b0101110, 1'b0);
    step();
    ip_hamm_code = 7'b0101001;
    ip_valid     = 1'b1;
    repeat (4) step();
    checks++;
    if (op_uncorr_cnt !== 8'd1 || op_corr_cnt !== 8'd2 ||
        op_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst got %0d %0d v=%b want 1 2 1",
               op_uncorr_cnt, op_corr_cnt, op_valid);
    end
    #2;
    ip_rst_n = 1'b0;
    #1;
    checks++;
    if (op_valid !== 1'b0 || op_corr_cnt !== 8'd0 ||
        op_uncorr_cnt !== 8'd0 || op_data !== 4'h0) begin
      errors++;
      $display("FAIL async_rst got v=%b %0d %0d d=%h want 0 0 0 0",
               op_valid, op_corr_cnt, op_uncorr_cnt, op_data);
    end
    ip_valid = 1'b0;
    step();
    ip_rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (op_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_rst op_valid got %b want 0", op_valid);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_corr = 0;
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_parity();
    test_positions();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
